// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline enable/flush/bubble control with load-use, flag-use, branch and memory-freeze handling
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_cond_br,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_set_flags,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             flag_en,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam bit         MEM_FREEZES = (MEM_LAT > 1);
  localparam logic [3:0] CNT_INIT    = MEM_FREEZES ? 4'(MEM_LAT - 2) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       load_use;
  logic       flag_use;
  logic       freeze;

  // XZR reads as zero, so a load targeting X31 never feeds a dependent.
  assign load_use = ex_mem_read && (ex_rd != 5'd31) &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
  assign flag_use = id_cond_br && ex_set_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && MEM_FREEZES) begin
          freeze    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        // Final cycle of an access: mem_req still belongs to it, so it is not re-armed here.
        if (cnt != 4'd0) begin
          freeze  = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || flag_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign flag_en = ex_set_flags && exmem_en;
  assign busy    = (state == MEM_WAIT) && !reset;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl at MEM_LAT 4, 1 and 3
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic       cbr;
    logic       mrd;
    logic [4:0] rd;
    logic       sf;
    logic       bt;
    logic       mq;
  } stim_t;

  // {pc, ifid, idex, exmem, memwb, flush, bubble, flag, busy}
  localparam logic [8:0] NORM = 9'b111110000;
  localparam logic [8:0] STL  = 9'b001110100;
  localparam logic [8:0] BRN  = 9'b111111100;
  localparam logic [8:0] FRZ  = 9'b000000000;
  localparam logic [8:0] RST  = 9'b000001100;
  localparam logic [8:0] BSY  = 9'b000000001;
  localparam logic [8:0] FLG  = 9'b000000010;

`ifdef STALL_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic       clk;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, id_cond_br, ex_mem_read, ex_set_flags, ex_br_taken, mem_req;

  logic pc4, ifid4, idex4, exmem4, memwb4, flush4, bub4, flag4, busy4;
  logic pc1, ifid1, idex1, exmem1, memwb1, flush1, bub1, flag1, busy1;
  logic pc3, ifid3, idex3, exmem3, memwb3, flush3, bub3, flag3, busy3;
  logic [31:0] sc4, sc1, sc3;
  logic [8:0]  o4, o1, o3;

  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  assign o4 = {pc4, ifid4, idex4, exmem4, memwb4, flush4, bub4, flag4, busy4};
  assign o1 = {pc1, ifid1, idex1, exmem1, memwb1, flush1, bub1, flag1, busy1};
  assign o3 = {pc3, ifid3, idex3, exmem3, memwb3, flush3, bub3, flag3, busy3};

  pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(32)) u4 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn),
    .id_uses_rm(id_uses_rm), .id_cond_br(id_cond_br), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_set_flags(ex_set_flags), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .pc_en(pc4), .ifid_en(ifid4), .idex_en(idex4), .exmem_en(exmem4), .memwb_en(memwb4),
    .ifid_flush(flush4), .idex_bubble(bub4), .flag_en(flag4), .busy(busy4), .stall_cycles(sc4));

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn),
    .id_uses_rm(id_uses_rm), .id_cond_br(id_cond_br), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_set_flags(ex_set_flags), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .pc_en(pc1), .ifid_en(ifid1), .idex_en(idex1), .exmem_en(exmem1), .memwb_en(memwb1),
    .ifid_flush(flush1), .idex_bubble(bub1), .flag_en(flag1), .busy(busy1), .stall_cycles(sc1));

  pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(32)) u3 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn),
    .id_uses_rm(id_uses_rm), .id_cond_br(id_cond_br), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_set_flags(ex_set_flags), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .pc_en(pc3), .ifid_en(ifid3), .idex_en(idex3), .exmem_en(exmem3), .memwb_en(memwb3),
    .ifid_flush(flush3), .idex_bubble(bub3), .flag_en(flag3), .busy(busy3), .stall_cycles(sc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t st(input logic r, input logic [4:0] rn, input logic [4:0] rm,
                               input logic urn, input logic urm, input logic cbr, input logic mrd,
                               input logic [4:0] rd, input logic sf, input logic bt, input logic mq);
    st = '{rst: r, rn: rn, rm: rm, urn: urn, urm: urm, cbr: cbr, mrd: mrd, rd: rd, sf: sf, bt: bt, mq: mq};
  endfunction

  task automatic apply(input stim_t s);
    reset        = s.rst;
    id_rn        = s.rn;
    id_rm        = s.rm;
    id_uses_rn   = s.urn;
    id_uses_rm   = s.urm;
    id_cond_br   = s.cbr;
    ex_mem_read  = s.mrd;
    ex_rd        = s.rd;
    ex_set_flags = s.sf;
    ex_br_taken  = s.bt;
    mem_req      = s.mq;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(st(1, 5, 0, 1, 0, 1, 1, 5, 1, 1, 1));
      exp_q.push_back(RST); exp_q.push_back(RST); exp_q.push_back(RST);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (o4 !== e) begin failures++; $display("FAIL reset_u4[%0d] got=%b exp=%b", i, o4, e); end
      e = exp_q.pop_front(); checks++;
      if (o1 !== e) begin failures++; $display("FAIL reset_u1[%0d] got=%b exp=%b", i, o1, e); end
      e = exp_q.pop_front(); checks++;
      if (o3 !== e) begin failures++; $display("FAIL reset_u3[%0d] got=%b exp=%b", i, o3, e); end
    end
    @(posedge clk); #1;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(NORM);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (o4 !== e) begin failures++; $display("FAIL reset_release got=%b exp=%b", o4, e); end
    checks++;
    if ((sc4 | sc1 | sc3) !== 32'd0) begin
      failures++; $display("FAIL reset_stall_cnt got=%0d/%0d/%0d exp=0", sc4, sc1, sc3);
    end
  endtask

  task automatic test_load_use();
    stim_t s[5];
    logic [8:0] ev[5];
    logic [8:0] e;
    s[0] = st(0, 2, 0, 1, 0, 0, 1, 2, 0, 0, 0);  ev[0] = STL;
    s[1] = st(0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);  ev[1] = NORM;
    s[2] = st(0, 0, 7, 0, 1, 0, 1, 7, 0, 0, 0);  ev[2] = STL;
    s[3] = st(0, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0);  ev[3] = NORM;
    s[4] = st(0, 3, 0, 1, 0, 0, 1, 4, 1, 0, 0);  ev[4] = NORM | FLG;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o4 !== e) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, o4, e); end
    end
  endtask

  task automatic test_xzr_branch();
    stim_t s[4];
    logic [8:0] ev[4];
    logic [8:0] e;
    s[0] = st(0, 31, 31, 1, 1, 0, 1, 31, 0, 0, 0);  ev[0] = NORM;
    s[1] = st(0, 5, 0, 1, 0, 0, 1, 5, 0, 1, 0);     ev[1] = BRN;
    s[2] = st(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);     ev[2] = BRN | FLG;
    s[3] = st(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);     ev[3] = STL | FLG;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o4 !== e) begin failures++; $display("FAIL xzr_branch[%0d] got=%b exp=%b", i, o4, e); end
    end
  endtask

  task automatic test_freeze();
    stim_t s[9];
    logic [8:0] ev[9];
    logic [8:0] e;
    s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[0] = FRZ;
    s[1] = st(0, 5, 0, 1, 0, 0, 1, 5, 0, 1, 1);  ev[1] = FRZ | BSY;
    s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  ev[2] = FRZ | BSY;
    s[3] = st(0, 5, 0, 1, 0, 0, 1, 5, 0, 0, 1);  ev[3] = STL | BSY;
    s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[4] = FRZ;
    s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[5] = FRZ | BSY;
    s[6] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[6] = FRZ | BSY;
    s[7] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  ev[7] = NORM | BSY | FLG;
    s[8] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[8] = NORM;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o4 !== e) begin failures++; $display("FAIL freeze_lat4[%0d] got=%b exp=%b", i, o4, e); end
    end
  endtask

  task automatic test_mem_lat1();
    stim_t s[5];
    logic [8:0] ev[5];
    logic [8:0] e;
    s[0] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[0] = NORM;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[1] = NORM;
    s[2] = st(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);  ev[2] = STL | FLG;
    s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[3] = NORM;
    s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  ev[4] = BRN;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o1 !== e) begin failures++; $display("FAIL mem_lat1[%0d] got=%b exp=%b", i, o1, e); end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t s[7];
    logic [8:0] ev[7];
    logic [8:0] e;
    s[0] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[0] = RST;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[1] = FRZ;
    s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[2] = FRZ | BSY;
    s[3] = st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  ev[3] = RST;
    s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[4] = NORM;
    s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[5] = FRZ;
    s[6] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[6] = RST;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o4 !== e) begin failures++; $display("FAIL reset_mid_wait[%0d] got=%b exp=%b", i, o4, e); end
    end
  endtask

  task automatic test_perf_cnt();
    stim_t s[9];
    logic [8:0] ev[9];
    logic [8:0] e;
    s[0] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[0] = RST;
    s[1] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[1] = FRZ;
    s[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[2] = FRZ | BSY;
    s[3] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[3] = NORM | BSY;
    s[4] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  ev[4] = FRZ;
    s[5] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[5] = FRZ | BSY;
    s[6] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[6] = NORM | BSY;
    s[7] = st(0, 9, 0, 1, 0, 0, 1, 9, 0, 0, 0);  ev[7] = STL;
    s[8] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  ev[8] = NORM;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(ev[i]);
      @(negedge clk); e = exp_q.pop_front(); checks++;
      if (o3 !== e) begin failures++; $display("FAIL perf_lat3[%0d] got=%b exp=%b", i, o3, e); end
      if (i == 1) begin
        checks++;
        if (sc3 !== 32'd0) begin failures++; $display("FAIL perf_cleared got=%0d exp=0", sc3); end
      end
    end
    checks++;
    if (sc3 !== PERF_EXP) begin failures++; $display("FAIL perf_count got=%0d exp=%0d", sc3, PERF_EXP); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_load_use();
    test_xzr_branch();
    test_freeze();
    test_mem_lat1();
    test_reset_mid_wait();
    test_perf_cnt();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
